// File: rtl/tff_mode_counter.sv
// -----------------------------------------------------------------------------
// tff_mode_counter
//
// A WIDTH-bit register built from T flip-flops. Each bit updates as
// q[i] <= q[i] ^ tv[i], and only the toggle vector tv depends on the mode:
//   mode 00  per-bit toggle mask (tv = t)
//   mode 01  binary up count
//   mode 10  binary down count
//   mode 11  parallel load (tv = q ^ d, so q becomes d)
// When an up or down count reaches its limit, tc pulses and the sticky ovf
// flag is set. With SATURATE = 1, q holds at the limit instead of wrapping.
//
// Parameters:
//   WIDTH     number of flip-flops (min 2)
//   SATURATE  0 = wrap at the count limits, 1 = hold at the limit
//   RST_VAL   value loaded into q on reset
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset
//   en       in   operation enable (0 = q holds, tc = 0)
//   mode     in   2-bit operation select (see above)
//   t        in   per-bit toggle mask, used in mode 00 only
//   d        in   parallel load data, used in mode 11 only
//   clr_ovf  in   clears the sticky overflow flag (a limit event wins)
//   q        out  flip-flop outputs, registered
//   tc       out  terminal-count pulse, registered
//   ovf      out  sticky overflow/underflow flag, registered
// -----------------------------------------------------------------------------
module tff_mode_counter #(
    parameter int               WIDTH    = 4,
    parameter bit               SATURATE = 1'b0,
    parameter logic [WIDTH-1:0] RST_VAL  = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] t,
    input  logic [WIDTH-1:0] d,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             ovf
);

    localparam logic [1:0] MODE_TOGGLE = 2'b00;
    localparam logic [1:0] MODE_UP     = 2'b01;
    localparam logic [1:0] MODE_DOWN   = 2'b10;
    localparam logic [1:0] MODE_LOAD   = 2'b11;

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             tc_q;
    logic             tc_d;
    logic             ovf_q;
    logic             ovf_d;

    logic [WIDTH-1:0] up_tv_s;
    logic [WIDTH-1:0] dn_tv_s;
    logic [WIDTH-1:0] tv_s;
    logic             limit_s;

    // Counting toggle vectors: bit i toggles when all lower bits are 1 (up) or 0 (down).
    always_comb begin
        up_tv_s    = {WIDTH{1'b0}};
        dn_tv_s    = {WIDTH{1'b0}};
        up_tv_s[0] = 1'b1;
        dn_tv_s[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            up_tv_s[i] = up_tv_s[i-1] & q_q[i-1];
            dn_tv_s[i] = dn_tv_s[i-1] & ~q_q[i-1];
        end
    end

    // Limit event: counting past all-ones (up) or past zero (down) while enabled.
    always_comb begin
        limit_s = 1'b0;
        if (en) begin
            case (mode)
                MODE_UP:   limit_s = (q_q == {WIDTH{1'b1}});
                MODE_DOWN: limit_s = (q_q == {WIDTH{1'b0}});
                default:   limit_s = 1'b0;
            endcase
        end else begin
            limit_s = 1'b0;
        end
    end

    // Mode-dependent toggle vector; saturation freezes q at the limit.
    always_comb begin
        tv_s = {WIDTH{1'b0}};
        if (!en) begin
            tv_s = {WIDTH{1'b0}};
        end else if (SATURATE && limit_s) begin
            tv_s = {WIDTH{1'b0}};
        end else begin
            case (mode)
                MODE_TOGGLE: tv_s = t;
                MODE_UP:     tv_s = up_tv_s;
                MODE_DOWN:   tv_s = dn_tv_s;
                MODE_LOAD:   tv_s = q_q ^ d;
                default:     tv_s = {WIDTH{1'b0}};
            endcase
        end
    end

    // Next-state values for q, tc and ovf; a limit event beats clr_ovf.
    always_comb begin
        q_d   = q_q ^ tv_s;
        tc_d  = limit_s;
        ovf_d = ovf_q;
        if (limit_s) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q   <= RST_VAL;
            tc_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            tc_q  <= tc_d;
            ovf_q <= ovf_d;
        end
    end

    assign q   = q_q;
    assign tc  = tc_q;
    assign ovf = ovf_q;

endmodule

// File: tb/tb_tff_mode_counter.sv
// -----------------------------------------------------------------------------
// tb_tff_mode_counter
//
// Directed bench for tff_mode_counter with WIDTH = 4 and RST_VAL = 4'h5.
// Two instances share the same stimulus: dut_w wraps (SATURATE = 0) and
// dut_s saturates (SATURATE = 1). Expected values are hand-computed.
// -----------------------------------------------------------------------------
module tb_tff_mode_counter;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst;
    logic             en;
    logic [1:0]       mode;
    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] d;
    logic             clr_ovf;

    logic [WIDTH-1:0] q_w;
    logic             tc_w;
    logic             ovf_w;
    logic [WIDTH-1:0] q_s;
    logic             tc_s;
    logic             ovf_s;

    int n_vec;
    int n_err;

    tff_mode_counter #(
        .WIDTH    (WIDTH),
        .SATURATE (1'b0),
        .RST_VAL  (4'h5)
    ) dut_w (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .mode    (mode),
        .t       (t),
        .d       (d),
        .clr_ovf (clr_ovf),
        .q       (q_w),
        .tc      (tc_w),
        .ovf     (ovf_w)
    );

    tff_mode_counter #(
        .WIDTH    (WIDTH),
        .SATURATE (1'b1),
        .RST_VAL  (4'h5)
    ) dut_s (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .mode    (mode),
        .t       (t),
        .d       (d),
        .clr_ovf (clr_ovf),
        .q       (q_s),
        .tc      (tc_s),
        .ovf     (ovf_s)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every vector and reports any miscompare.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (obs !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle past it before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check both instances after an edge.
    task automatic chk_both(input string tag,
                            input logic [3:0] wq, input logic wtc, input logic wovf,
                            input logic [3:0] sq, input logic stc, input logic sovf);
        chk({tag, " w.q"},   {28'd0, q_w},   {28'd0, wq});
        chk({tag, " w.tc"},  {31'd0, tc_w},  {31'd0, wtc});
        chk({tag, " w.ovf"}, {31'd0, ovf_w}, {31'd0, wovf});
        chk({tag, " s.q"},   {28'd0, q_s},   {28'd0, sq});
        chk({tag, " s.tc"},  {31'd0, tc_s},  {31'd0, stc});
        chk({tag, " s.ovf"}, {31'd0, ovf_s}, {31'd0, sovf});
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        rst     = 1'b1;
        en      = 1'b1;
        mode    = 2'b01;
        t       = 4'h0;
        d       = 4'h0;
        clr_ovf = 1'b0;

        // Reset held two edges while enabled in up mode.
        step();
        step();
        chk_both("reset", 4'h5, 1'b0, 1'b0, 4'h5, 1'b0, 1'b0);

        // Three up-counts from RST_VAL.
        rst = 1'b0;
        step(); chk_both("up1", 4'h6, 1'b0, 1'b0, 4'h6, 1'b0, 1'b0);
        step(); chk_both("up2", 4'h7, 1'b0, 1'b0, 4'h7, 1'b0, 1'b0);
        step(); chk_both("up3", 4'h8, 1'b0, 1'b0, 4'h8, 1'b0, 1'b0);

        // Toggle mask.
        mode = 2'b11; d = 4'h0;
        step(); chk_both("ld0", 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
        mode = 2'b00; t = 4'b1010;
        step(); chk_both("tgl1", 4'hA, 1'b0, 1'b0, 4'hA, 1'b0, 1'b0);
        t = 4'b0011;
        step(); chk_both("tgl2", 4'h9, 1'b0, 1'b0, 4'h9, 1'b0, 1'b0);

        // Up wrap (dut_w) versus up saturate (dut_s).
        mode = 2'b11; d = 4'hE;
        step(); chk_both("ldE", 4'hE, 1'b0, 1'b0, 4'hE, 1'b0, 1'b0);
        mode = 2'b01;
        step(); chk_both("upF", 4'hF, 1'b0, 1'b0, 4'hF, 1'b0, 1'b0);
        step(); chk_both("upwrap", 4'h0, 1'b1, 1'b1, 4'hF, 1'b1, 1'b1);
        step(); chk_both("uppost", 4'h1, 1'b0, 1'b1, 4'hF, 1'b1, 1'b1);

        // Clear the sticky flag with no limit event.
        mode = 2'b00; t = 4'h0; clr_ovf = 1'b1;
        step(); chk_both("clr", 4'h1, 1'b0, 1'b0, 4'hF, 1'b0, 1'b0);
        clr_ovf = 1'b0;

        // Down count from 1: wrap versus saturate at zero.
        mode = 2'b11; d = 4'h1;
        step(); chk_both("ld1", 4'h1, 1'b0, 1'b0, 4'h1, 1'b0, 1'b0);
        mode = 2'b10;
        step(); chk_both("dn1", 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
        step(); chk_both("dn2", 4'hF, 1'b1, 1'b1, 4'h0, 1'b1, 1'b1);
        step(); chk_both("dn3", 4'hE, 1'b0, 1'b1, 4'h0, 1'b1, 1'b1);

        // Simultaneous set and clear: set wins.
        mode = 2'b11; d = 4'h0; clr_ovf = 1'b1;
        step(); chk_both("ldclr", 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
        mode = 2'b10;
        step(); chk_both("setwin", 4'hF, 1'b1, 1'b1, 4'h0, 1'b1, 1'b1);
        clr_ovf = 1'b0;

        // Enable low holds q, drops tc, keeps ovf.
        mode = 2'b11; d = 4'h7;
        step(); chk_both("ld7", 4'h7, 1'b0, 1'b1, 4'h7, 1'b0, 1'b1);
        en = 1'b0; mode = 2'b01;
        for (int i = 0; i < 3; i++) begin
            step(); chk_both("hold", 4'h7, 1'b0, 1'b1, 4'h7, 1'b0, 1'b1);
        end

        // Reset at a pending up limit discards the wrap.
        en = 1'b1; mode = 2'b11; d = 4'hF;
        step(); chk_both("ldF", 4'hF, 1'b0, 1'b1, 4'hF, 1'b0, 1'b1);
        mode = 2'b01; rst = 1'b1;
        step(); chk_both("midrst", 4'h5, 1'b0, 1'b0, 4'h5, 1'b0, 1'b0);

        // After reset, nothing happens until an enabled edge.
        rst = 1'b0; en = 1'b0;
        step(); chk_both("postrst", 4'h5, 1'b0, 1'b0, 4'h5, 1'b0, 1'b0);
        en = 1'b1;
        step(); chk_both("firstop", 4'h6, 1'b0, 1'b0, 4'h6, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tff_mode_counter.md
# tff_mode_counter

Parametrised multi-mode register built from WIDTH T-type flip-flops, each with its own toggle input. It is the next generation of the single-bit toggle latch/flop. It adds:
- a per-bit toggle-mask mode,
- binary up and down counting,
- parallel load,
- a terminal-count pulse and a sticky overflow flag.

It is used as a general-purpose event counter and bit-toggle register in the sequential-circuit library.

## Interface
Parameters:
- WIDTH, 4: number of T flip-flops and width of q, t, d (min 2).
- SATURATE, 0: 0 = wrap at count limits; 1 = hold at the limit.
- RST_VAL, 0: value loaded into q on reset (WIDTH bits).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  operation enable; 0 = q holds.
- mode  in  2  00 toggle-mask, 01 count up, 10 count down, 11 load.
- t  in  WIDTH  per-bit toggle mask (mode 00 only).
- d  in  WIDTH  parallel load data (mode 11 only).
- clr_ovf  in  1  clears the sticky overflow flag.
- q  out  WIDTH  flip-flop outputs, registered.
- tc  out  1  terminal-count pulse, registered, one cycle.
- ovf  out  1  sticky overflow/underflow flag, registered.

## Operation
- Every bit is a T flip-flop: q[i] <= q[i] ^ tv[i]. Only the toggle vector tv is mode dependent.
  - mode 00: tv = t.
  - mode 01 (up): tv[0] = 1; tv[i] = &q[i-1:0].
  - mode 10 (down): tv[0] = 1; tv[i] = &(~q[i-1:0]).
  - mode 11 (load): tv = q ^ d, so q becomes d.
- Priority per edge: rst > en = 0 > mode.
- rst = 1:
  - q <= RST_VAL; tc <= 0; ovf <= 0.
  - Overrides en, mode and clr_ovf.
- en = 0:
  - tv = 0, so q holds; tc <= 0.
  - ovf holds, except that clr_ovf still clears it.
- Limit event: a limit event is one of the following.
  - mode 01 with q == all-ones and en = 1.
  - mode 10 with q == 0 and en = 1.
- At a limit event:
  - SATURATE = 0: q wraps (all-ones -> 0, or 0 -> all-ones), tc <= 1, ovf <= 1.
  - SATURATE = 1: tv forced to 0, so q holds at the limit; tc <= 1 and ovf <= 1 on every edge the condition persists.
- Modes 00 and 11 never raise tc or ovf. tc <= 0 in those modes.
- tc is 1 for exactly the cycle following a limit edge, unless the next edge is also a limit event (saturate hold, or WIDTH-limited repeats).
- clr_ovf = 1 with no limit event: ovf <= 0.
- clr_ovf = 1 together with a limit event on the same edge: set wins, ovf <= 1.
- Mode changes take effect on the same edge. There is no pipeline and no internal state beyond q, tc and ovf.
- Arithmetic is modulo 2^WIDTH. There is no carry output beyond tc and ovf.

## Timing
- Reset values: q = RST_VAL, tc = 0, ovf = 0, all visible after the first rising edge with rst = 1.
- Latency: 1 cycle from inputs sampled at edge N to q, tc and ovf valid after edge N.
- Outputs come directly from flops. There are no combinational input-to-output paths.
- Reset asserted mid-count or mid-saturation: the next edge forces reset values and discards any pending limit event.
- After rst deasserts, the first operation happens on the next edge with en = 1.

## Test plan
All scenarios use WIDTH = 4.
- Reset: rst = 1 for 2 cycles with RST_VAL = 4'h5, en = 1, mode = 01 -> q = 5, tc = 0, ovf = 0. rst = 0, then 3 up-counts -> q = 6, 7, 8.
- Toggle mask: q = 0, mode 00, t = 1010, one edge -> q = 1010. Second edge with t = 0011 -> q = 1001. tc and ovf stay 0.
- Up wrap, SATURATE = 0: load d = 4'hE, then count up 3 edges:
  - q = F, then 0 with tc = 1 for one cycle and ovf = 1, then 1 with tc = 0 and ovf still 1.
  - Then clr_ovf = 1 for one edge -> ovf = 0.
- Down saturate, SATURATE = 1: load 1, count down 3 edges -> q = 0, 0, 0; tc = 0, 1, 1; ovf = 1.
- Simultaneous set and clear: q = 0, mode 10, SATURATE = 0, clr_ovf = 1 on the same edge -> q = F, ovf = 1 (set wins), tc = 1.
- Enable and mid-operation reset:
  - en = 0 for 3 edges in mode 01 with q = 7 -> q stays 7, tc = 0.
  - Then rst = 1 while en = 1 and q = F in mode 01 -> q = RST_VAL, tc = 0, ovf = 0. No wrap is recorded.
